conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameters SHALL be: IP_DATA_WIDTH, 8, operand width; IFMAP_SIZE, 5, ifmap side; FILTER_SIZE, 3, filter side; STRIDE, 1, window step; OFMAP_SIZE, (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1, ofmap side (derived).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one full convolution.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  ifmap/filter read strobe.
- ifmap_addr  out  $clog2(IFMAP_SIZE*IFMAP_SIZE)  ifmap word address.
- flt_addr  out  $clog2(FILTER_SIZE*FILTER_SIZE)  filter word address.
- ifmap_data  in  IP_DATA_WIDTH  unsigned, valid one cycle after rd_en.
- flt_data  in  IP_DATA_WIDTH  unsigned, valid one cycle after rd_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*IP_DATA_WIDTH  window sum.
- res_row  out  $clog2(OFMAP_SIZE)  output row index.
- res_col  out  $clog2(OFMAP_SIZE)  output column index.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, DRAIN, OUT and DONE.
REQ-004 IDLE SHALL go to ISSUE when start is high; otherwise it stays in IDLE. start SHALL be ignored in every other state.
REQ-005 ISSUE SHALL last exactly K=FILTER_SIZE*FILTER_SIZE cycles, with rd_en=1 and one (ky,kx) per cycle in raster order (kx fastest).
REQ-006 Address rules:
- ifmap_addr = (oy*STRIDE+ky)*IFMAP_SIZE + (ox*STRIDE+kx).
- flt_addr = ky*FILTER_SIZE+kx.
REQ-007 DRAIN SHALL last 1 cycle with rd_en=0, then go to OUT.
REQ-008 The accumulator SHALL clear on entry to each window's first ISSUE cycle.
REQ-009 The accumulator SHALL add ifmap_data*flt_data on each cycle following an rd_en cycle.
REQ-010 Product and sum SHALL be truncated to 2*IP_DATA_WIDTH (modulo wrap) unless CONV_CTRL_SAT_EN is defined.
REQ-011 In OUT, res_valid=1, and res_data/res_row/res_col SHALL hold stable until the cycle where res_valid&&res_ready.
REQ-012 While OUT is stalled, no reads SHALL issue.
REQ-013 Latency: with first ISSUE cycle T, res_valid SHALL rise in cycle T+K+1.
REQ-014 On handshake of a non-last window, the FSM SHALL go to ISSUE for the next window in the following cycle.
REQ-015 Windows SHALL be processed in raster order (ox fastest, oy = res_row, ox = res_col).
REQ-016 On handshake of window (OFMAP_SIZE-1, OFMAP_SIZE-1), the FSM SHALL go to DONE.
REQ-017 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-018 A handshake SHALL be accepted in the same cycle res_valid first rises if res_ready is already high.

Reset
REQ-019 When rst is high at a rising edge, the state SHALL be IDLE, the accumulator and all indices 0, and all outputs 0 (busy, done, rd_en, addresses, res_*).
REQ-020 Reset SHALL take priority over all inputs, including reset asserted mid-ISSUE or mid-OUT.
REQ-021 After reset, no stale result SHALL be presented.

Configuration
REQ-022 With CONV_CTRL_SAT_EN defined, the accumulator SHALL saturate at 2^(2*IP_DATA_WIDTH)-1 and hold that value for the rest of the window.
REQ-023 With CONV_CTRL_SAT_EN undefined, the accumulator SHALL wrap modulo 2^(2*IP_DATA_WIDTH).

Structure
REQ-024 Package conv_pkg SHALL hold:
- the FSM state enum typedef (conv_state_t);
- default width constants;
- an address-width helper function.
REQ-025 The window and kernel counters and address arithmetic SHALL be in one sub-module, conv_addr_gen.
REQ-026 The FSM, accumulator and result register SHALL be in conv_ctrl.

Verification
REQ-027 Ifmap all 1, filter all 1, res_ready=1 -> nine results all 9, in order (0,0)..(2,2); done pulses once; busy drops with done.
REQ-028 Ifmap[i]=i, filter centre=1 and others 0 -> results 6,7,8,11,12,13,16,17,18.
REQ-029 res_ready low 3 cycles during window (1,1) -> res_* stable, rd_en=0 throughout; sequence resumes with no lost or duplicated window.
REQ-030 start pulsed while busy -> ignored: exactly nine results and a single done pulse.
REQ-031 rst asserted during ISSUE of window (0,2) -> next cycle IDLE, all outputs 0; a new start yields the full correct nine-result sequence.
REQ-032 Ifmap all 255, filter all 255 -> result 60937 without CONV_CTRL_SAT_EN; 65535 with it.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default widths and an address-width helper for conv_ctrl.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } conv_state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IFMAP_SIZE  = 5;
    localparam int DEF_FILTER_SIZE = 3;
    localparam int DEF_STRIDE      = 1;

    // Never returns zero, so a single-entry range still gets a legal vector width.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: kernel (ky,kx) and window (oy,ox) raster counters plus ifmap/filter address arithmetic.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IFMAP_SIZE  = DEF_IFMAP_SIZE,
    parameter int FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int STRIDE      = DEF_STRIDE,
    parameter int OFMAP_SIZE  = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        step_k_i,
    input  logic                                        step_w_i,
    output logic                                        k_last_o,
    output logic                                        w_last_o,
    output logic [addr_w(IFMAP_SIZE*IFMAP_SIZE)-1:0]    ifmap_addr_o,
    output logic [addr_w(FILTER_SIZE*FILTER_SIZE)-1:0]  flt_addr_o,
    output logic [addr_w(OFMAP_SIZE)-1:0]               oy_o,
    output logic [addr_w(OFMAP_SIZE)-1:0]               ox_o
);

    localparam int IW = addr_w(IFMAP_SIZE * IFMAP_SIZE);
    localparam int FW = addr_w(FILTER_SIZE * FILTER_SIZE);
    localparam int KW = addr_w(FILTER_SIZE);
    localparam int OW = addr_w(OFMAP_SIZE);

    logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;
    logic [OW-1:0] oy_q, oy_d, ox_q, ox_d;
    logic          kx_end, ky_end, ox_end, oy_end;

    assign kx_end = kx_q == KW'(FILTER_SIZE - 1);
    assign ky_end = ky_q == KW'(FILTER_SIZE - 1);
    assign ox_end = ox_q == OW'(OFMAP_SIZE - 1);
    assign oy_end = oy_q == OW'(OFMAP_SIZE - 1);

    always_comb begin
        kx_d = !step_k_i ? kx_q : kx_end ? '0 : kx_q + 1'b1;
        ky_d = !(step_k_i && kx_end) ? ky_q : ky_end ? '0 : ky_q + 1'b1;
        ox_d = !step_w_i ? ox_q : ox_end ? '0 : ox_q + 1'b1;
        oy_d = !(step_w_i && ox_end) ? oy_q : oy_end ? '0 : oy_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ky_q <= '0;
            kx_q <= '0;
            oy_q <= '0;
            ox_q <= '0;
        end else begin
            ky_q <= ky_d;
            kx_q <= kx_d;
            oy_q <= oy_d;
            ox_q <= ox_d;
        end
    end

    assign k_last_o     = kx_end && ky_end;
    assign w_last_o     = ox_end && oy_end;
    assign ifmap_addr_o = IW'((int'(oy_q) * STRIDE + int'(ky_q)) * IFMAP_SIZE
                              + int'(ox_q) * STRIDE + int'(kx_q));
    assign flt_addr_o   = FW'(int'(ky_q) * FILTER_SIZE + int'(kx_q));
    assign oy_o         = oy_q;
    assign ox_o         = ox_q;

endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences a full 2-D convolution (FSM, multiply-accumulate, result handshake).
// Define CONV_CTRL_SAT_EN to saturate the accumulator instead of wrapping.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int IP_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IFMAP_SIZE    = DEF_IFMAP_SIZE,
    parameter int FILTER_SIZE   = DEF_FILTER_SIZE,
    parameter int STRIDE        = DEF_STRIDE,
    parameter int OFMAP_SIZE    = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          rd_en,
    output logic [$clog2(IFMAP_SIZE*IFMAP_SIZE)-1:0]      ifmap_addr,
    output logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0]    flt_addr,
    input  logic [IP_DATA_WIDTH-1:0]                      ifmap_data,
    input  logic [IP_DATA_WIDTH-1:0]                      flt_data,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [2*IP_DATA_WIDTH-1:0]                    res_data,
    output logic [$clog2(OFMAP_SIZE)-1:0]                 res_row,
    output logic [$clog2(OFMAP_SIZE)-1:0]                 res_col
);

    localparam int AW = 2 * IP_DATA_WIDTH;

    conv_state_t   state_q, state_d;
    logic [AW-1:0] acc_q, acc_d, res_q, res_d, prod, acc_sum;
    logic [AW:0]   sum;
    logic          rd_q, k_last, w_last;

    conv_addr_gen #(
        .IFMAP_SIZE  (IFMAP_SIZE),
        .FILTER_SIZE (FILTER_SIZE),
        .STRIDE      (STRIDE),
        .OFMAP_SIZE  (OFMAP_SIZE)
    ) u_addr (
        .clk          (clk),
        .rst          (rst),
        .step_k_i     (state_q == S_ISSUE),
        .step_w_i     (state_q == S_OUT && res_ready),
        .k_last_o     (k_last),
        .w_last_o     (w_last),
        .ifmap_addr_o (ifmap_addr),
        .flt_addr_o   (flt_addr),
        .oy_o         (res_row),
        .ox_o         (res_col)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = start ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = k_last ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   state_d = !res_ready ? S_OUT : w_last ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lands one cycle after rd_en, so the add is keyed off the delayed strobe.
    always_comb begin
        prod = AW'(ifmap_data) * AW'(flt_data);
        sum  = {1'b0, acc_q} + {1'b0, prod};
`ifdef CONV_CTRL_SAT_EN
        acc_sum = sum[AW] ? '1 : sum[AW-1:0];
`else
        acc_sum = sum[AW-1:0];
`endif
        acc_d = rd_q ? acc_sum : (state_q == S_ISSUE) ? acc_q : '0;
        res_d = (state_q == S_DRAIN) ? acc_d : res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            rd_q    <= rd_en;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign rd_en     = state_q == S_ISSUE;
    assign res_valid = state_q == S_OUT;
    assign res_data  = res_q;

endmodule
